cusp_filter_cfg: RTL

Second-generation cusp-like shaping filter for the ADC channel. It implements the same recursive dk/dl/p/q/s structure as the first generation and adds:
- runtime-programmable k, l, m1, m2 and output shift;
- sample-enable handshake;
- a warm-up state machine;
- output saturation and a configuration-error flag.

It sits between the ADC capture logic and the peak/energy extraction stage.

---
 rtl/cusp_pkg.sv | 34 +++
 rtl/cusp_delay_line.sv | 35 +++
 rtl/cusp_filter_cfg.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/cusp_pkg.sv
// rtl/cusp_pkg.sv - shared constants, state encoding and configuration record for the cusp filter
package cusp_pkg;

    localparam int CFG_K_W   = 6;
    localparam int CFG_M_W   = 8;
    localparam int CFG_SH_W  = 5;
    localparam int CFG_K_MAX = 32;

    localparam logic [CFG_K_W-1:0]  K_DEF  = 6'd11;
    localparam logic [CFG_K_W-1:0]  L_DEF  = 6'd5;
    localparam logic [CFG_M_W-1:0]  M1_DEF = 8'd16;
    localparam logic [CFG_M_W-1:0]  M2_DEF = 8'd1;
    localparam logic [CFG_SH_W-1:0] SH_DEF = 5'd4;

    typedef enum logic [1:0] {
        FLUSH,
        WARMUP,
        RUN
    } state_t;

    typedef struct packed {
        logic [CFG_K_W-1:0]  k;
        logic [CFG_K_W-1:0]  l;
        logic [CFG_M_W-1:0]  m1;
        logic [CFG_M_W-1:0]  m2;
        logic [CFG_SH_W-1:0] shift;
    } cfg_t;

    // Taps reach back to v(n-k) and v(n-l-1), so l+1 must not exceed k.
    function automatic logic cfg_ok(cfg_t c);
        return (c.l >= 6'd1) && (c.l < c.k) && (c.k <= 6'(CFG_K_MAX));
    endfunction

endpackage

// File: rtl/cusp_delay_line.sv
// rtl/cusp_delay_line.sv - sample history with taps at v(n-k), v(n-l) and v(n-l-1)
module cusp_delay_line
    import cusp_pkg::*;
#(
    parameter int DW    = 12,
    parameter int DEPTH = 33
) (
    input  logic               clk,
    input  logic               clr_i,
    input  logic               en_i,
    input  logic [DW-1:0]      data_i,
    input  logic [CFG_K_W-1:0] k_i,
    input  logic [CFG_K_W-1:0] l_i,
    output logic [DW-1:0]      tap_k_o,
    output logic [DW-1:0]      tap_l_o,
    output logic [DW-1:0]      tap_l1_o
);

    logic [DW-1:0] line_q [DEPTH];

    always_ff @(posedge clk) begin
        if (clr_i) begin
            for (int i = 0; i < DEPTH; i++) line_q[i] <= '0;
        end else if (en_i) begin
            line_q[0] <= data_i;
            for (int i = 1; i < DEPTH; i++) line_q[i] <= line_q[i-1];
        end
    end

    // line_q[j] holds v(n-1-j) while sample n is presented on data_i.
    assign tap_k_o  = line_q[k_i - 6'd1];
    assign tap_l_o  = line_q[l_i - 6'd1];
    assign tap_l1_o = line_q[l_i];

endmodule

// File: rtl/cusp_filter_cfg.sv
// rtl/cusp_filter_cfg.sv - configurable cusp shaping filter, 5-stage pipeline with warm-up control
module cusp_filter_cfg
    import cusp_pkg::*;
#(
    parameter int ADC_W = 12,
    parameter int OUT_W = 16,
    parameter int ACC_W = 40,
    parameter int K_MAX = 32,
    parameter int M_W   = 8,
    parameter int SH_W  = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [ADC_W-1:0] in_data,
    input  logic             in_valid,
    input  logic             cfg_load,
    input  logic [5:0]       cfg_k,
    input  logic [5:0]       cfg_l,
    input  logic [M_W-1:0]   cfg_m1,
    input  logic [M_W-1:0]   cfg_m2,
    input  logic [SH_W-1:0]  cfg_shift,
    output logic             cfg_err,
    output logic             busy,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    output logic             out_sat
);

    localparam int DW = ADC_W + 1;
    localparam logic signed [ACC_W-1:0] SAT_HI = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

    state_t     state_q, state_d;
    cfg_t       cfg_q, cfg_d, cfg_new;
    logic [6:0] cnt_q, cnt_d, warm_len;
    logic       load_ok, load_bad, clear, accept, show;
    logic       cfg_err_q, out_valid_q, out_sat_q;
    logic [OUT_W-1:0] out_data_q, sat_val;
    logic       sat_hit;

    logic [ADC_W-1:0] tap_k, tap_l, tap_l1;
    logic [3:0]       v_q, show_q;
    logic signed [DW-1:0]    dk_q, dl_q, dk_d, dl_d;
    logic signed [ACC_W-1:0] dk_x, dl_x, k_x, m1_x, m2_x;
    logic signed [ACC_W-1:0] p_q, q_q, m1p_q, s_q, shifted;

    assign cfg_new  = '{k: cfg_k, l: cfg_l, m1: cfg_m1, m2: cfg_m2, shift: cfg_shift};
    assign load_ok  = cfg_load && cfg_ok(cfg_new);
    assign load_bad = cfg_load && !load_ok;
    assign clear    = (state_q == FLUSH) || load_ok;
    assign accept   = in_valid && !cfg_load && (state_q != FLUSH);
    assign show     = (state_q == RUN);
    assign warm_len = {1'b0, cfg_q.k} + {1'b0, cfg_q.l} + 7'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FLUSH;
            cfg_q     <= '{k: K_DEF, l: L_DEF, m1: M1_DEF, m2: M2_DEF, shift: SH_DEF};
            cnt_q     <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cfg_q     <= cfg_d;
            cnt_q     <= cnt_d;
            cfg_err_q <= load_bad;
        end
    end

    always_comb begin
        state_d = state_q;
        cfg_d   = cfg_q;
        cnt_d   = cnt_q;
        if (load_ok) begin
            cfg_d   = cfg_new;
            state_d = FLUSH;
        end else begin
            case (state_q)
                FLUSH: begin
                    state_d = WARMUP;
                    cnt_d   = '0;
                end
                WARMUP: begin
                    if (accept) begin
                        cnt_d = cnt_q + 7'd1;
                        if (cnt_q + 7'd1 == warm_len) state_d = RUN;
                    end
                end
                default: ;
            endcase
        end
    end

    cusp_delay_line #(.DW(ADC_W), .DEPTH(K_MAX + 1)) u_delay (
        .clk      (clk),
        .clr_i    (reset || clear),
        .en_i     (accept),
        .data_i   (in_data),
        .k_i      (cfg_q.k),
        .l_i      (cfg_q.l),
        .tap_k_o  (tap_k),
        .tap_l_o  (tap_l),
        .tap_l1_o (tap_l1)
    );

    assign dk_d = $signed({1'b0, in_data}) - $signed({1'b0, tap_k});
    assign dl_d = $signed({1'b0, tap_l}) - $signed({1'b0, tap_l1});
    assign dk_x = {{(ACC_W-DW){dk_q[DW-1]}}, dk_q};
    assign dl_x = {{(ACC_W-DW){dl_q[DW-1]}}, dl_q};
    assign k_x  = {{(ACC_W-6){1'b0}}, cfg_q.k};
    assign m1_x = {{(ACC_W-M_W){1'b0}}, cfg_q.m1};
    assign m2_x = {{(ACC_W-M_W){1'b0}}, cfg_q.m2};

    // Stage n reads the previous stage's register, so one sample per cycle never collides.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            v_q         <= '0;
            show_q      <= '0;
            dk_q        <= '0;
            dl_q        <= '0;
            p_q         <= '0;
            q_q         <= '0;
            m1p_q       <= '0;
            s_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            v_q    <= {v_q[2:0], accept};
            show_q <= {show_q[2:0], accept && show};
            if (accept) begin
                dk_q <= dk_d;
                dl_q <= dl_d;
            end
            if (v_q[0]) p_q <= p_q + dk_x - k_x * dl_x;
            if (v_q[1]) begin
                q_q   <= q_q + m2_x * p_q;
                m1p_q <= m1_x * p_q;
            end
            if (v_q[2]) s_q <= s_q + q_q + m1p_q;
            out_valid_q <= v_q[3] && show_q[3];
        end
    end

    always_comb begin
        shifted = s_q >>> cfg_q.shift;
        sat_hit = 1'b1;
        if (shifted > SAT_HI) begin
            sat_val = SAT_HI[OUT_W-1:0];
        end else if (shifted < SAT_LO) begin
            sat_val = SAT_LO[OUT_W-1:0];
        end else begin
            sat_val = shifted[OUT_W-1:0];
            sat_hit = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_data_q <= '0;
            out_sat_q  <= 1'b0;
        end else begin
            if (v_q[3] && show_q[3] && !clear) out_data_q <= sat_val;
            if (load_ok) out_sat_q <= 1'b0;
            else if (v_q[3] && show_q[3] && !clear && sat_hit) out_sat_q <= 1'b1;
        end
    end

    assign cfg_err   = cfg_err_q;
    assign busy      = (state_q != RUN);
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_sat   = out_sat_q;

endmodule
